// File: rtl/tl_sequencer.sv
// Four-approach traffic light sequencer with protected left turns and an
// all-red pedestrian walk phase inserted after B-left when requested.
module tl_sequencer #(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 16,
  parameter int unsigned YELLOW    = 2,
  parameter int unsigned WALK      = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       Tal,
  input  logic       Tbl,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lal,
  output logic [1:0] Lb,
  output logic [1:0] Lbl,
  output logic       walk,
  output logic [3:0] state
);

  localparam int unsigned TW = 6;

  localparam logic [3:0] S0 = 4'd0;
  localparam logic [3:0] S1 = 4'd1;
  localparam logic [3:0] S2 = 4'd2;
  localparam logic [3:0] S3 = 4'd3;
  localparam logic [3:0] S4 = 4'd4;
  localparam logic [3:0] S5 = 4'd5;
  localparam logic [3:0] S6 = 4'd6;
  localparam logic [3:0] S7 = 4'd7;
  localparam logic [3:0] S8 = 4'd8;

  localparam logic [1:0] GREEN = 2'b00;
  localparam logic [1:0] AMBER = 2'b01;
  localparam logic [1:0] RED   = 2'b10;

  localparam logic [TW-1:0] MIN_M1  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_M1  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] WALK_M1 = TW'(WALK - 1);

  logic [3:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pend_q, ped_pend_d;
  logic          advance;
  logic          green_sensor;
  logic [3:0]    next_phase;

  // State, dwell timer and pending-pedestrian flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S0;
      timer_q    <= '0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // Next-state decision and light decode from the registered phase.
  always_comb begin
    advance      = 1'b0;
    green_sensor = 1'b0;
    next_phase   = S0;
    La           = RED;
    Lal          = RED;
    Lb           = RED;
    Lbl          = RED;
    walk         = 1'b0;

    case (state_q)
      S0: green_sensor = Ta;
      S2: green_sensor = Tal;
      S4: green_sensor = Tb;
      S6: green_sensor = Tbl;
      default: green_sensor = 1'b0;
    endcase

    case (state_q)
      S0, S2, S4, S6: begin
        advance    = (!green_sensor && (timer_q >= MIN_M1)) || (timer_q == MAX_M1);
        next_phase = state_q + 4'd1;
      end
      S1, S3, S5: begin
        advance    = (timer_q == YEL_M1);
        next_phase = state_q + 4'd1;
      end
      S7: begin
        advance    = (timer_q == YEL_M1);
        next_phase = ped_pend_q ? S8 : S0;
      end
      S8: begin
        advance    = (timer_q == WALK_M1);
        next_phase = S0;
      end
      default: begin
        advance    = 1'b1;
        next_phase = S0;
      end
    endcase

    state_d = advance ? next_phase : state_q;
    timer_d = advance ? '0 : timer_q + TW'(1);

    // A request coinciding with the walk entry is absorbed by that walk.
    ped_pend_d = ped_pend_q;
    if (ped_req && (state_q != S8)) ped_pend_d = 1'b1;
    if (advance && (state_q == S7) && ped_pend_q) ped_pend_d = 1'b0;

    case (state_q)
      S0: La  = GREEN;
      S1: La  = AMBER;
      S2: Lal = GREEN;
      S3: Lal = AMBER;
      S4: Lb  = GREEN;
      S5: Lb  = AMBER;
      S6: Lbl = GREEN;
      S7: Lbl = AMBER;
      S8: walk = 1'b1;
      default: walk = 1'b0;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_tl_sequencer.sv
// Bench for tl_sequencer: reset/vector table, hand-built timing sequences and
// a randomized run against a phase-level reference model.
module tb_tl_sequencer;

  localparam int MIN_G = 4;
  localparam int MAX_G = 16;
  localparam int YEL   = 2;
  localparam int WLK   = 6;

  logic       clk;
  logic       reset_n;
  logic       Ta, Tb, Tal, Tbl, ped_req;
  logic [1:0] La, Lal, Lb, Lbl;
  logic       walk;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  bit walk_seen;

  int m_phase, m_t;
  bit m_pend;

  typedef struct {
    logic ta;
    logic tal;
    logic ped;
    int   exp_state;
  } vec_t;

  vec_t vecs[12];

  tl_sequencer #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW(YEL), .WALK(WLK)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .Ta(Ta), .Tb(Tb), .Tal(Tal), .Tbl(Tbl), .ped_req(ped_req),
    .La(La), .Lal(Lal), .Lb(Lb), .Lbl(Lbl), .walk(walk), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Approach order: 0=A straight, 1=A left, 2=B straight, 3=B left.
  function automatic int exp_light(input int st, input int ap);
    if (st < 8 && st / 2 == ap) return (st % 2 == 1) ? 1 : 0;
    return 2;
  endfunction

  task automatic check_outputs(input string tag, input int st);
    check($sformatf("%s.state", tag), int'(state), st);
    check($sformatf("%s.La", tag),  int'(La),  exp_light(st, 0));
    check($sformatf("%s.Lal", tag), int'(Lal), exp_light(st, 1));
    check($sformatf("%s.Lb", tag),  int'(Lb),  exp_light(st, 2));
    check($sformatf("%s.Lbl", tag), int'(Lbl), exp_light(st, 3));
    check($sformatf("%s.walk", tag), int'(walk), (st == 8) ? 1 : 0);
  endtask

  task automatic set_inputs(input logic ta, input logic tb, input logic tal,
                            input logic tbl, input logic ped);
    Ta = ta; Tb = tb; Tal = tal; Tbl = tbl; ped_req = ped;
  endtask

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_pend = 1'b0;
  endtask

  // Predicts the phase after the coming rising edge from this cycle's inputs.
  task automatic model_step(input logic ta, input logic tb, input logic tal,
                            input logic tbl, input logic ped);
    logic sens[4];
    int   t1, nxt;
    bit   leave, new_pend;
    sens  = '{ta, tal, tb, tbl};
    t1    = m_t + 1;
    leave = 1'b0;
    nxt   = 0;
    if (m_phase == 8) begin
      leave = (t1 == WLK);
    end else if (m_phase % 2 == 0) begin
      leave = (!sens[m_phase / 2] && t1 >= MIN_G) || (t1 == MAX_G);
      nxt   = m_phase + 1;
    end else begin
      leave = (t1 == YEL);
      nxt   = (m_phase == 7) ? (m_pend ? 8 : 0) : m_phase + 1;
    end
    new_pend = (ped && m_phase != 8) ? 1'b1 : m_pend;
    if (leave && nxt == 8) new_pend = 1'b0;
    m_pend  = new_pend;
    m_t     = leave ? 0 : t1;
    m_phase = leave ? nxt : m_phase;
  endtask

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Steps cycles until the state equals s; n counts the steps taken.
  task automatic wait_for(input int s, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (walk) walk_seen = 1'b1;
    end while (int'(state) != s && n < 200);
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_for state=%0d actual=timeout expected=reached", s);
    end
  endtask

  initial begin
    int n1, n2, n3, total;
    reset_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0);

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 3};

    #2;
    check_outputs("reset_hold", 0);

    // Vector table: sensor changes never alter outputs of the same cycle.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_inputs(vecs[i].ta, 1'b0, vecs[i].tal, 1'b0, vecs[i].ped);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_state);
      @(negedge clk);
    end
    set_inputs(0, 0, 0, 0, 0);

    // Mid-cycle asynchronous reset.
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_outputs("async_rst", 0);

    // Ta held high: green forced out at the maximum.
    set_inputs(1, 0, 0, 0, 0);
    do_reset();
    wait_for(1, n1);
    check("max_green_len", n1, MAX_G);
    wait_for(2, n2);
    check("yellow_len", n2, YEL);

    // All idle: 24-cycle period, no walk.
    set_inputs(0, 0, 0, 0, 0);
    do_reset();
    walk_seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_for(1, n1);
      wait_for(0, n2);
      check($sformatf("idle_period%0d", k), n1 + n2, 24);
    end
    check("idle_no_walk", int'(walk_seen), 0);

    // Request during A-left: walk inserted, request during walk ignored.
    do_reset();
    wait_for(2, n1);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_for(8, n2);
    check_outputs("walk_entry", 8);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    check_outputs("walk_mid", 8);
    wait_for(0, n3);
    check("walk_len", n3 + 1, WLK);
    total = n1 + 1 + n2 + n3 + 1;
    check("ped_cycle_len", total, 30);
    wait_for(1, n1);
    wait_for(0, n2);
    check("after_ped_period", n1 + n2, 24);

    // Request on the S7->S8 edge counts as serviced.
    do_reset();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_for(7, n1);
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    check("edge_req_state", int'(state), 8);
    wait_for(0, n1);
    check("edge_req_walk", n1, WLK);
    wait_for(1, n1);
    wait_for(0, n2);
    check("edge_req_next", n1 + n2, 24);

    // Reset during B yellow clears the pending request.
    do_reset();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_for(5, n1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_outputs("rst_in_s5", 0);
    @(negedge clk);
    reset_n = 1'b1;
    walk_seen = 1'b0;
    wait_for(1, n1);
    wait_for(0, n2);
    check("rst_clears_pend", n1 + n2, 24);
    check("rst_no_walk", int'(walk_seen), 0);

    // Randomized run against the reference model.
    set_inputs(0, 0, 0, 0, 0);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int p;
      logic ta, tb, tal, tbl, pd;
      #1;
      check_outputs("rnd", m_phase);
      p   = (c / 500) % 3;
      ta  = ($urandom_range(0, 3) < p + 1);
      tb  = ($urandom_range(0, 3) < p + 1);
      tal = ($urandom_range(0, 3) < p + 1);
      tbl = ($urandom_range(0, 3) < p + 1);
      pd  = ($urandom_range(0, 23) == 0);
      set_inputs(ta, tb, tal, tbl, pd);
      model_step(ta, tb, tal, tbl, pd);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_sequencer.md
TL_SEQUENCER -- requirements
Module: tl_sequencer

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 4, minimum cycles in any green phase (1 <= MIN_GREEN <= MAX_GREEN).
REQ-002 The block SHALL have parameter MAX_GREEN, default 16, maximum cycles in any green phase (<= 63).
REQ-003 The block SHALL have parameter YELLOW, default 2, cycles in every yellow phase (1..63).
REQ-004 The block SHALL have parameter WALK, default 6, cycles in the all-red pedestrian phase (1..63).
REQ-005 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports Ta, Tb, Tal, Tbl, input, 1 each, traffic sensors for A straight, B straight, A left and B left; 1 = traffic present.
REQ-008 The block SHALL have port ped_req, input, 1, pedestrian request; any cycle at 1 counts as a request.
REQ-009 The block SHALL have ports La, Lal, Lb, Lbl, output, 2 each, light codes: 2'b00 green, 2'b01 yellow, 2'b10 red.
REQ-010 The block SHALL have port walk, output, 1, pedestrian walk lamp.
REQ-011 The block SHALL have port state, output, 4, current phase for debug.

Function
REQ-012 The block SHALL implement a registered Moore FSM with phases S0 A green, S1 A yellow, S2 A-left green, S3 A-left yellow, S4 B green, S5 B yellow, S6 B-left green, S7 B-left yellow and S8 walk, encoded 0..8.
REQ-013 The block SHALL keep a 6-bit dwell timer that is 0 in the first cycle of every phase and increments by 1 each cycle in that phase.
REQ-014 Each green phase (S0/S2/S4/S6, sensors Ta/Tal/Tb/Tbl respectively) SHALL advance to the next phase when (sensor==0 and timer>=MIN_GREEN-1) or timer==MAX_GREEN-1.
REQ-015 Each yellow phase SHALL advance when timer==YELLOW-1: S1->S2, S3->S4, S5->S6, S7->S8 if ped_pend else S0.
REQ-016 S8 SHALL advance to S0 when timer==WALK-1.
REQ-017 Encodings 9..15 SHALL go to S0 on the next edge, with all lights red and walk 0 while held.
REQ-018 The block SHALL set internal flag ped_pend on any cycle with ped_req==1 outside S8, and clear it on the edge entering S8; requests during S8 SHALL be ignored.
REQ-019 When a ped_req occurs in the same cycle as the S7->S8 transition, the request SHALL be treated as serviced, leaving ped_pend 0.
REQ-020 Outputs SHALL be decoded from the registered state only:
- the served light is 00 in its green phase and 01 in its yellow phase; all other lights are 10
- S8 drives all lights 10 and walk=1; walk=0 in every other phase.
REQ-021 Sensor changes SHALL affect only the next-state decision, never the outputs in the same cycle.

Reset
REQ-022 On reset_n==0 the block SHALL immediately, regardless of clk, set state=S0, timer=0 and ped_pend=0, giving La=00, Lal=10, Lb=10, Lbl=10, walk=0.
REQ-023 After reset_n rises, S0 timing SHALL start from timer=0 on the first rising edge of clk.

Verification
REQ-024 The bench SHALL assert reset in mid-cycle -> state=0, La=00, other lights 10, walk=0 immediately without a clock edge.
REQ-025 The bench SHALL hold Ta=0 from reset release -> S0 for 4 cycles, S1 (La=01) for 2 cycles, S2 (Lal=00) on cycle 7.
REQ-026 The bench SHALL hold Ta=1 -> S0 forced out after exactly 16 cycles, then S1 for 2 cycles.
REQ-027 The bench SHALL hold all sensors 0 and ped_req=0 -> S0..S7 repeat with a 24-cycle period, and walk is never 1.
REQ-028 The bench SHALL pulse ped_req for 1 cycle during S2 -> after S7 comes S8 for 6 cycles (walk=1, all lights 10), then S0; cycle length 30, and the next cycle without a request is 24.
REQ-029 The bench SHALL assert reset_n=0 during S5 with ped_pend=1 -> state=0 and ped_pend=0, and the next full cycle skips S8.
